soc_thermal_governor: RTL
=========================

// Module: soc_thermal_governor
// PURPOSE
//  Bus initiator that drives the SoC control CSR block, issuing the requests that block serves.
//  Every POLL_CYCLES it visits one core, round-robin: reads its temperature CSR, steps that core's
//  PLL feedback divider down (hot) or up (cool), writes it back and polls the PLL lock CSR.
//  Sits on the system clock next to the control block; single outstanding transaction.
// PARAMETERS
//  NUM_CORE 4 : cores governed
//  XLEN 64 : bus address/data width
//  FB_DIV_WIDTH 12 : PLL feedback divider width
//  TEMP_SENSOR_WIDTH 10 : temperature field width (rdata[TEMP_SENSOR_WIDTH-1:0])
//  CSR_BASE 64'h0 : control CSR base address
//  TEMP_OFF 'h100 / FBDIV_OFF 'h200 : per-core register arrays, stride 8 bytes
//  LOCK_OFF 'h300 : lock vector register, bit n = core n PLL locked
//  TEMP_HI 800 / TEMP_LO 700 : throttle / boost thresholds (unsigned)
//  FB_DIV_INIT 32, FB_DIV_MIN 16, FB_DIV_MAX 64, FB_DIV_STEP 4 : divider shadow range
//  POLL_CYCLES 1024 : cycles between core visits; LOCK_TRIES 16 : lock reads before giving up
// PORTS
//  clk_i          in  1     system clock
//  arst_ni        in  1     async active-low reset
//  en_i           in  1     governor enable
//  req_valid_o    out 1     request valid
//  req_ready_i    in  1     request accepted
//  req_addr_o     out XLEN  byte address
//  req_we_o       out 1     1 = write, 0 = read
//  req_wdata_o    out XLEN  write data (zero-extended divider)
//  rsp_valid_i    in  1     response valid (always accepted)
//  rsp_rdata_i    in  XLEN  read data
//  rsp_err_i      in  1     response error
//  throttle_vec_o out NUM_CORE  core currently below FB_DIV_INIT
//  busy_o         out 1     state != IDLE
//  err_o          out 1     sticky: any rsp_err_i seen
//  lock_fail_o    out 1     sticky: LOCK_TRIES exhausted
// BEHAVIOUR
//  Reset: all outputs 0; shadows = FB_DIV_INIT; core index 0; timer = POLL_CYCLES-1; state IDLE.
//  FSM: IDLE -> RD_TEMP -> WAIT_TEMP -> DECIDE -> WR_DIV -> WAIT_WR -> RD_LOCK -> WAIT_LOCK -> NEXT -> IDLE.
//  IDLE: timer decrements while en_i=1; at 0 with en_i=1 go RD_TEMP; timer reloads. en_i=0 freezes timer.
//  Request states: assert req_valid_o with addr/we/wdata stable until req_ready_i=1, then go to WAIT_*.
//   Handshake completes in the same cycle as ready; req_valid_o drops next cycle.
//  Addresses: temp = CSR_BASE+TEMP_OFF+8*n; div = CSR_BASE+FBDIV_OFF+8*n; lock = CSR_BASE+LOCK_OFF.
//  rsp_valid_i outside WAIT_* states is ignored. No timeout on responses.
//  DECIDE (1 cycle), t = rdata temperature, d = shadow[n]:
//   t > TEMP_HI -> d' = max(d-STEP, MIN); t < TEMP_LO -> d' = min(d+STEP, MAX); else d' = d.
//   Saturation is computed without underflow. If d' == d, skip to NEXT: no write, no lock poll.
//  WAIT_WR ok: shadow[n] <= d'; go RD_LOCK; try counter = 0.
//  WAIT_LOCK:
//   - rdata[n]=1 -> NEXT.
//   - Else try+1; retry RD_LOCK while try < LOCK_TRIES.
//   - Otherwise set lock_fail_o -> NEXT.
//  Any rsp_err_i in WAIT_*: set err_o; shadow unchanged; go NEXT (core skipped).
//  NEXT: n <= (n == NUM_CORE-1) ? 0 : n+1.
//  throttle_vec_o[n] = shadow[n] < FB_DIV_INIT, registered.
//  en_i dropping mid-sequence: the current core visit completes; then the block stays in IDLE.
//  err_o and lock_fail_o are cleared only by reset.
// TESTING
//  1. Temp 850 on core0, ok responses -> one write of 28 to FBDIV_OFF+0, then one lock read; throttle_vec_o[0]=1.
//  2. Temp 600, shadow 64 -> no write issued; index advances to core1 after POLL_CYCLES.
//  3. Lock bit low 16 reads -> exactly 16 lock reads; lock_fail_o=1; next core visited.
//  4. req_ready_i held low 10 cycles -> req_* stable for all 10 cycles; single transaction.
//  5. rsp_err_i on temperature read -> err_o=1; no write; shadow unchanged.
//  6. en_i=0 during WAIT_WR -> sequence finishes; then no req_valid_o for 3*POLL_CYCLES.

Source files
------------

// File: rtl/soc_thermal_governor.sv
// Thermal governor: bus initiator that visits one core per poll period, reads its temperature,
// steps the PLL feedback divider toward the safe range and confirms the PLL has relocked.
module soc_thermal_governor #(
    parameter int unsigned      NUM_CORE          = 4,
    parameter int unsigned      XLEN              = 64,
    parameter int unsigned      FB_DIV_WIDTH      = 12,
    parameter int unsigned      TEMP_SENSOR_WIDTH = 10,
    parameter logic [XLEN-1:0]  CSR_BASE          = '0,
    parameter int unsigned      TEMP_OFF          = 'h100,
    parameter int unsigned      FBDIV_OFF         = 'h200,
    parameter int unsigned      LOCK_OFF          = 'h300,
    parameter int unsigned      TEMP_HI           = 800,
    parameter int unsigned      TEMP_LO           = 700,
    parameter int unsigned      FB_DIV_INIT       = 32,
    parameter int unsigned      FB_DIV_MIN        = 16,
    parameter int unsigned      FB_DIV_MAX        = 64,
    parameter int unsigned      FB_DIV_STEP       = 4,
    parameter int unsigned      POLL_CYCLES       = 1024,
    parameter int unsigned      LOCK_TRIES        = 16
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                en_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [XLEN-1:0]     req_addr_o,
    output logic                req_we_o,
    output logic [XLEN-1:0]     req_wdata_o,
    input  logic                rsp_valid_i,
    input  logic [XLEN-1:0]     rsp_rdata_i,
    input  logic                rsp_err_i,
    output logic [NUM_CORE-1:0] throttle_vec_o,
    output logic                busy_o,
    output logic                err_o,
    output logic                lock_fail_o
);

    localparam int unsigned IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int unsigned TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned TRY_W = $clog2(LOCK_TRIES + 1);
    localparam int unsigned DW    = FB_DIV_WIDTH;
    localparam int unsigned TW    = TEMP_SENSOR_WIDTH;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CORE - 1);
    localparam logic [TRY_W-1:0] TRY_MAX    = TRY_W'(LOCK_TRIES);
    localparam logic [TW-1:0]    T_HI       = TW'(TEMP_HI);
    localparam logic [TW-1:0]    T_LO       = TW'(TEMP_LO);
    localparam logic [DW-1:0]    DIV_INIT   = DW'(FB_DIV_INIT);
    localparam logic [DW-1:0]    DIV_MIN    = DW'(FB_DIV_MIN);
    localparam logic [DW-1:0]    DIV_MAX    = DW'(FB_DIV_MAX);
    localparam logic [DW-1:0]    DIV_STEP   = DW'(FB_DIV_STEP);
    // Saturation bounds precomputed so the divider step never wraps.
    localparam logic [DW-1:0]    DIV_FLOOR  = DW'(FB_DIV_MIN + FB_DIV_STEP);
    localparam logic [DW-1:0]    DIV_CEIL   = DW'(FB_DIV_MAX - FB_DIV_STEP);
    localparam logic [XLEN-1:0]  TEMP_BASE  = CSR_BASE + XLEN'(TEMP_OFF);
    localparam logic [XLEN-1:0]  DIV_BASE   = CSR_BASE + XLEN'(FBDIV_OFF);
    localparam logic [XLEN-1:0]  LOCK_ADDR  = CSR_BASE + XLEN'(LOCK_OFF);

    typedef enum logic [3:0] {
        IDLE, RD_TEMP, WAIT_TEMP, DECIDE, WR_DIV, WAIT_WR, RD_LOCK, WAIT_LOCK, NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TW-1:0]     temp_q;
    logic [TRY_W-1:0]  try_q;
    logic [TRY_W-1:0]  try_inc;
    logic [DW-1:0]     shadow_q [NUM_CORE];
    logic [DW-1:0]     div_cur;
    logic [DW-1:0]     div_new;
    logic [NUM_CORE-1:0] throttle_q;
    logic              err_q;
    logic              lock_fail_q;
    logic [XLEN-1:0]   core_off;
    logic              lock_ok;

    assign div_cur  = shadow_q[idx_q];
    assign try_inc  = try_q + 1'b1;
    assign core_off = XLEN'({idx_q, 3'b000});
    assign lock_ok  = rsp_rdata_i[idx_q];

    // Temperature and shadow are stable from DECIDE through WAIT_WR, so the new divider
    // is derived combinationally instead of being stored.
    always_comb begin
        div_new = div_cur;
        if (temp_q > T_HI) begin
            div_new = (div_cur >= DIV_FLOOR) ? div_cur - DIV_STEP : DIV_MIN;
        end else if (temp_q < T_LO) begin
            div_new = (div_cur <= DIV_CEIL) ? div_cur + DIV_STEP : DIV_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (en_i && timer_q == '0) state_d = RD_TEMP;
            RD_TEMP:   if (req_ready_i) state_d = WAIT_TEMP;
            WAIT_TEMP: if (rsp_valid_i) state_d = rsp_err_i ? NEXT : DECIDE;
            DECIDE:    state_d = (div_new == div_cur) ? NEXT : WR_DIV;
            WR_DIV:    if (req_ready_i) state_d = WAIT_WR;
            WAIT_WR:   if (rsp_valid_i) state_d = rsp_err_i ? NEXT : RD_LOCK;
            RD_LOCK:   if (req_ready_i) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (rsp_valid_i) begin
                    if (rsp_err_i || lock_ok) state_d = NEXT;
                    else if (try_inc < TRY_MAX) state_d = RD_LOCK;
                    else state_d = NEXT;
                end
            end
            NEXT:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid_o = 1'b0;
        req_addr_o  = '0;
        req_we_o    = 1'b0;
        req_wdata_o = '0;
        unique case (state_q)
            RD_TEMP: begin
                req_valid_o = 1'b1;
                req_addr_o  = TEMP_BASE + core_off;
            end
            WR_DIV: begin
                req_valid_o = 1'b1;
                req_addr_o  = DIV_BASE + core_off;
                req_we_o    = 1'b1;
                req_wdata_o = XLEN'(div_new);
            end
            RD_LOCK: begin
                req_valid_o = 1'b1;
                req_addr_o  = LOCK_ADDR;
            end
            default: ;
        endcase
    end

    // NOTE: the divider shadows are a handful of flops whose contents define the
    // power-on operating point, so they are reset rather than left as plain storage.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            timer_q     <= TMR_RELOAD;
            idx_q       <= '0;
            temp_q      <= '0;
            try_q       <= '0;
            throttle_q  <= '0;
            err_q       <= 1'b0;
            lock_fail_q <= 1'b0;
            for (int i = 0; i < NUM_CORE; i++) shadow_q[i] <= DIV_INIT;
        end else begin
            if (state_q == IDLE && en_i) begin
                timer_q <= (timer_q == '0) ? TMR_RELOAD : timer_q - 1'b1;
            end
            if (rsp_valid_i && rsp_err_i &&
                (state_q == WAIT_TEMP || state_q == WAIT_WR || state_q == WAIT_LOCK)) begin
                err_q <= 1'b1;
            end
            if (state_q == WAIT_TEMP && rsp_valid_i && !rsp_err_i) begin
                temp_q <= rsp_rdata_i[TW-1:0];
            end
            if (state_q == WAIT_WR && rsp_valid_i && !rsp_err_i) begin
                shadow_q[idx_q]   <= div_new;
                throttle_q[idx_q] <= (div_new < DIV_INIT);
                try_q             <= '0;
            end
            if (state_q == WAIT_LOCK && rsp_valid_i && !rsp_err_i && !lock_ok) begin
                try_q <= try_inc;
                if (try_inc >= TRY_MAX) lock_fail_q <= 1'b1;
            end
            if (state_q == NEXT) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign throttle_vec_o = throttle_q;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;
    assign lock_fail_o    = lock_fail_q;

endmodule
